// File: rtl/jpeg_transform_ctrl.sv
// Collects one zigzag-ordered coefficient block and presents it with its
// selected quantisation table to the downstream transform.
module jpeg_transform_ctrl #(
  parameter int WIDTH_IN = 16,
  parameter int NUM_QT   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          qt_wr_en,
  input  logic [1:0]                    qt_wr_sel,
  input  logic [5:0]                    qt_wr_idx,
  input  logic [WIDTH_IN-1:0]           qt_wr_data,
  output logic                          qt_wr_err,
  input  logic                          coef_valid,
  output logic                          coef_ready,
  input  logic signed [WIDTH_IN-1:0]    coef_data,
  input  logic                          coef_last,
  input  logic [1:0]                    blk_qt_sel,
  output logic signed [WIDTH_IN*64-1:0] zz_out_flat,
  output logic [WIDTH_IN*64-1:0]        quant_out_flat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          blk_overrun
);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

  state_e              state_q, state_d;
  logic [5:0]          count_q;
  logic [1:0]          sel_q;
  logic [WIDTH_IN-1:0] buf_q [64];
  logic [WIDTH_IN-1:0] qt_q  [NUM_QT][64];
  logic                err_q;
  logic                ovr_q;
  logic                accept;
  logic                final_coef;

  assign accept     = coef_valid && coef_ready;
  assign final_coef = coef_last || (state_q == FILL && count_q == 6'd63);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, FILL: begin
        if (accept && final_coef) state_d = HOLD;
        else if (accept)          state_d = FILL;
      end
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coef_ready = (state_q != HOLD);
    out_valid  = (state_q == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      for (int unsigned e = 0; e < 64; e++) buf_q[e[5:0]] <= '0;
      for (int unsigned t = 0; t < NUM_QT; t++)
        for (int unsigned e = 0; e < 64; e++)
          qt_q[t[1:0]][e[5:0]] <= WIDTH_IN'(1);
    end else begin
      err_q <= 1'b0;
      if (qt_wr_en) begin
        // The table in use by a held block is write-protected.
        if (state_q == HOLD && qt_wr_sel == sel_q) err_q <= 1'b1;
        else if (int'(qt_wr_sel) < NUM_QT) qt_q[qt_wr_sel][qt_wr_idx] <= qt_wr_data;
      end
      if (accept) begin
        if (state_q == IDLE) begin
          // Wipe the stale block while entry 0 lands; the later NBA wins for entry 0.
          for (int unsigned e = 0; e < 64; e++) buf_q[e[5:0]] <= '0;
          buf_q[0] <= coef_data;
          sel_q    <= blk_qt_sel;
          count_q  <= 6'd1;
        end else begin
          buf_q[count_q] <= coef_data;
          count_q        <= count_q + 6'd1;
          if (count_q == 6'd63 && !coef_last) ovr_q <= 1'b1;
        end
      end else if (state_q == HOLD && out_ready) begin
        count_q <= '0;
      end
    end
  end

  always_comb begin
    zz_out_flat    = '0;
    quant_out_flat = '0;
    for (int unsigned k = 0; k < 64; k++) begin
      zz_out_flat[k*WIDTH_IN +: WIDTH_IN]    = buf_q[k[5:0]];
      quant_out_flat[k*WIDTH_IN +: WIDTH_IN] = qt_q[sel_q][k[5:0]];
    end
  end

  assign qt_wr_err   = err_q;
  assign blk_overrun = ovr_q;

endmodule

// File: tb/tb_jpeg_transform_ctrl.sv
// Self-checking bench for jpeg_transform_ctrl: directed corner sequences,
// a table of block shapes, and randomized traffic against a behavioural model.
module tb_jpeg_transform_ctrl;

  localparam int W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   qt_wr_en;
  logic [1:0]             qt_wr_sel;
  logic [5:0]             qt_wr_idx;
  logic [W-1:0]           qt_wr_data;
  logic                   qt_wr_err;
  logic                   coef_valid;
  logic                   coef_ready;
  logic signed [W-1:0]    coef_data;
  logic                   coef_last;
  logic [1:0]             blk_qt_sel;
  logic signed [W*64-1:0] zz_out_flat;
  logic [W*64-1:0]        quant_out_flat;
  logic                   out_valid;
  logic                   out_ready;
  logic                   blk_overrun;

  jpeg_transform_ctrl #(.WIDTH_IN(W), .NUM_QT(4)) dut (
    .clk(clk), .rst(rst),
    .qt_wr_en(qt_wr_en), .qt_wr_sel(qt_wr_sel), .qt_wr_idx(qt_wr_idx),
    .qt_wr_data(qt_wr_data), .qt_wr_err(qt_wr_err),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .coef_last(coef_last), .blk_qt_sel(blk_qt_sel),
    .zz_out_flat(zz_out_flat), .quant_out_flat(quant_out_flat),
    .out_valid(out_valid), .out_ready(out_ready), .blk_overrun(blk_overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: table contents, current block contents, flags.
  logic [W-1:0] ref_qt [4][64];
  logic [W-1:0] blk_data [64];
  int           blk_n;
  int           cur_sel;
  bit           in_hold;
  bit           ovr_model;

  typedef struct {
    int n;
    bit last;
    int sel;
    bit exp_valid;
    bit exp_ovr;
  } vec_t;
  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_flat(input string nm, input logic [W*64-1:0] got, input logic [W*64-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      for (int k = 0; k < 64; k++) begin
        if (got[k*W +: W] !== exp[k*W +: W]) begin
          $display("FAIL %s: entry %0d got %0h expected %0h", nm, k, got[k*W +: W], exp[k*W +: W]);
          break;
        end
      end
    end
  endtask

  function automatic logic [W*64-1:0] exp_zz();
    logic [W*64-1:0] e;
    for (int k = 0; k < 64; k++) e[k*W +: W] = (k < blk_n) ? blk_data[k] : '0;
    return e;
  endfunction

  function automatic logic [W*64-1:0] exp_qt();
    logic [W*64-1:0] e;
    for (int k = 0; k < 64; k++) e[k*W +: W] = ref_qt[cur_sel][k];
    return e;
  endfunction

  task automatic model_reset();
    for (int t = 0; t < 4; t++)
      for (int e = 0; e < 64; e++) ref_qt[t][e] = 16'd1;
    for (int e = 0; e < 64; e++) blk_data[e] = '0;
    blk_n = 0; cur_sel = 0; in_hold = 0; ovr_model = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; qt_wr_en = 1'b0; coef_valid = 1'b0; coef_last = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic qt_write(input int sel, input int idx, input int data);
    bit exp_err;
    qt_wr_en = 1'b1; qt_wr_sel = 2'(sel); qt_wr_idx = 6'(idx); qt_wr_data = W'(data);
    step();
    qt_wr_en = 1'b0;
    exp_err = in_hold && (sel == cur_sel);
    if (!exp_err) ref_qt[sel][idx] = W'(data);
    chk("qt_wr_err", qt_wr_err, exp_err);
  endtask

  // Offers blk_data[0..n-1]; rnd adds valid gaps, junk fields, out_ready noise and table writes.
  task automatic send_block(input int n, input bit with_last, input int sel, input bit rnd);
    int  i = 0;
    int  guard = 0;
    bit  accepted, w;
    int  ws, wi, wd;
    blk_n = n; cur_sel = sel;
    while (i < n) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        coef_valid = 1'b0; coef_data = W'($urandom);
        coef_last = 1'($urandom); blk_qt_sel = 2'($urandom);
      end else begin
        coef_valid = 1'b1; coef_data = blk_data[i];
        coef_last  = with_last && (i == n - 1);
        blk_qt_sel = (i == 0) ? 2'(sel) : 2'($urandom);
      end
      out_ready = rnd ? 1'($urandom) : 1'b0;
      w = rnd && ($urandom_range(0, 2) == 0);
      if (w) begin
        ws = $urandom_range(0, 3); wi = $urandom_range(0, 63); wd = $urandom_range(0, 65535);
        qt_wr_en = 1'b1; qt_wr_sel = 2'(ws); qt_wr_idx = 6'(wi); qt_wr_data = W'(wd);
      end else begin
        qt_wr_en = 1'b0;
      end
      accepted = coef_valid && coef_ready;
      step();
      if (w) begin
        ref_qt[ws][wi] = W'(wd);
        chk("qt_wr_err during fill", qt_wr_err, 0);
      end
      if (accepted) i++;
      guard++;
      if (guard > 1000) begin
        chk("send_block cycle budget", 0, 1);
        break;
      end
    end
    coef_valid = 1'b0; coef_last = 1'b0; qt_wr_en = 1'b0; out_ready = 1'b0;
    if (with_last || n == 64) in_hold = 1;
    if (n == 64 && !with_last) ovr_model = 1;
  endtask

  task automatic check_hold(input string nm);
    chk({nm, " out_valid"}, out_valid, 1);
    chk({nm, " coef_ready"}, coef_ready, 0);
    chk({nm, " blk_overrun"}, blk_overrun, ovr_model);
    chk_flat({nm, " zz"}, zz_out_flat, exp_zz());
    chk_flat({nm, " quant"}, quant_out_flat, exp_qt());
  endtask

  // Holds the block for waitc cycles with junk coefficients offered, then hands it off.
  task automatic release_blk(input bit rnd, input int waitc);
    bit w, exp_err;
    int ws, wi, wd;
    for (int c = 0; c < waitc; c++) begin
      out_ready = 1'b0;
      coef_valid = 1'b1; coef_data = W'($urandom); coef_last = 1'($urandom); blk_qt_sel = 2'($urandom);
      w = rnd && ($urandom_range(0, 1) == 1);
      if (w) begin
        ws = $urandom_range(0, 3); wi = $urandom_range(0, 63); wd = $urandom_range(0, 65535);
        qt_wr_en = 1'b1; qt_wr_sel = 2'(ws); qt_wr_idx = 6'(wi); qt_wr_data = W'(wd);
      end else begin
        qt_wr_en = 1'b0;
      end
      step();
      if (w) begin
        exp_err = (ws == cur_sel);
        if (!exp_err) ref_qt[ws][wi] = W'(wd);
        chk("qt_wr_err in hold", qt_wr_err, exp_err);
      end
      check_hold("held");
    end
    coef_valid = 1'b0; qt_wr_en = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_hold = 0;
    chk("after handshake out_valid", out_valid, 0);
    chk("after handshake coef_ready", coef_ready, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{n: 1,  last: 1'b1, sel: 0, exp_valid: 1'b1, exp_ovr: 1'b0};
    vecs[1] = '{n: 2,  last: 1'b1, sel: 1, exp_valid: 1'b1, exp_ovr: 1'b0};
    vecs[2] = '{n: 63, last: 1'b1, sel: 2, exp_valid: 1'b1, exp_ovr: 1'b0};
    vecs[3] = '{n: 64, last: 1'b1, sel: 3, exp_valid: 1'b1, exp_ovr: 1'b0};
    vecs[4] = '{n: 17, last: 1'b1, sel: 1, exp_valid: 1'b1, exp_ovr: 1'b0};
    vecs[5] = '{n: 64, last: 1'b0, sel: 2, exp_valid: 1'b1, exp_ovr: 1'b1};

    qt_wr_sel = '0; qt_wr_idx = '0; qt_wr_data = '0; coef_data = '0; blk_qt_sel = '0;
    do_reset();

    // Reset state
    chk("reset coef_ready", coef_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset qt_wr_err", qt_wr_err, 0);
    chk("reset blk_overrun", blk_overrun, 0);
    chk_flat("reset zz", zz_out_flat, exp_zz());
    chk_flat("reset quant", quant_out_flat, exp_qt());
    step();
    chk("post-reset coef_ready", coef_ready, 1);

    // Full block, table 0 loaded with 2s
    for (int k = 0; k < 64; k++) qt_write(0, k, 2);
    for (int k = 0; k < 64; k++) blk_data[k] = W'(k + 1);
    send_block(64, 1, 0, 0);
    check_hold("full block");
    chk("full block entry63", zz_out_flat[63*W +: W], 64);
    chk("full block quant0", quant_out_flat[0 +: W], 2);
    release_blk(0, 0);

    // Early EOB
    blk_data[0] = 16'd10; blk_data[1] = 16'hFFFB; blk_data[2] = 16'd7;
    send_block(3, 1, 0, 0);
    check_hold("eob");
    chk("eob entry3 zero", zz_out_flat[3*W +: W], 0);

    // Backpressure, then next block starts from a zeroed buffer
    release_blk(0, 0);
    for (int k = 0; k < 5; k++) blk_data[k] = W'($urandom);
    send_block(5, 1, 1, 0);
    check_hold("bp block");
    release_blk(0, 5);
    for (int k = 0; k < 2; k++) blk_data[k] = W'($urandom);
    send_block(2, 1, 1, 0);
    check_hold("bp next block");

    // Table protection with table 1 latched
    qt_write(1, 5, 99);
    chk_flat("protected table quant", quant_out_flat, exp_qt());
    qt_write(2, 5, 77);
    release_blk(0, 0);
    blk_data[0] = 16'd3;
    send_block(1, 1, 2, 0);
    check_hold("table2 written");
    chk("table2 entry5", quant_out_flat[5*W +: W], 77);
    release_blk(0, 0);

    // Table-driven block shapes
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < 64; k++) blk_data[k] = W'($urandom);
      send_block(vecs[v].n, vecs[v].last, vecs[v].sel, (v % 2) == 1);
      check_hold("vec");
      chk("vec out_valid", out_valid, vecs[v].exp_valid);
      chk("vec blk_overrun", blk_overrun, vecs[v].exp_ovr);
      release_blk((v % 2) == 1, $urandom_range(0, 3));
    end

    // Overrun stays sticky across later blocks
    for (int k = 0; k < 4; k++) blk_data[k] = W'($urandom);
    send_block(4, 1, 0, 1);
    check_hold("after overrun");
    chk("overrun sticky", blk_overrun, 1);
    release_blk(1, 2);

    // Reset in the middle of a fill
    qt_write(3, 0, 9);
    for (int k = 0; k < 20; k++) blk_data[k] = W'($urandom_range(1, 65535));
    send_block(20, 0, 3, 0);
    chk("mid fill out_valid", out_valid, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("rst mid fill out_valid", out_valid, 0);
    chk("rst mid fill coef_ready", coef_ready, 1);
    chk("rst mid fill overrun", blk_overrun, 0);
    chk_flat("rst mid fill zz", zz_out_flat, exp_zz());
    chk_flat("rst mid fill quant", quant_out_flat, exp_qt());
    blk_data[0] = 16'd4; blk_data[1] = 16'd5;
    send_block(2, 1, 3, 0);
    check_hold("after abandon");
    release_blk(0, 0);

    // Randomized traffic
    for (int it = 0; it < 25; it++) begin
      int n;
      bit last;
      n = $urandom_range(1, 64);
      last = (n < 64) ? 1'b1 : 1'($urandom);
      for (int k = 0; k < 64; k++) blk_data[k] = W'($urandom);
      send_block(n, last, $urandom_range(0, 3), 1);
      check_hold("random");
      release_blk(1, $urandom_range(0, 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jpeg_transform_ctrl.md
JPEG_TRANSFORM_CTRL -- requirements
Module: jpeg_transform_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 16, coefficient and quant entry width.
REQ-002 SHALL have parameter NUM_QT, default 4, number of quant tables (selector width 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port qt_wr_en, input, 1 bit: quant-table write strobe.
REQ-006 SHALL have port qt_wr_sel, input, 2 bits: target table.
REQ-007 SHALL have port qt_wr_idx, input, 6 bits: row-major entry index 0..63.
REQ-008 SHALL have port qt_wr_data, input, WIDTH_IN bits: unsigned quant value.
REQ-009 SHALL have port qt_wr_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-010 SHALL have port coef_valid, input, 1 bit: coefficient offered.
REQ-011 SHALL have port coef_ready, output, 1 bit: coefficient accepted when valid and ready are both high.
REQ-012 SHALL have port coef_data, input, WIDTH_IN bits, signed: coefficient in zigzag order.
REQ-013 SHALL have port coef_last, input, 1 bit: final coefficient of the block (EOB).
REQ-014 SHALL have port blk_qt_sel, input, 2 bits: table for the block, sampled with the first coefficient.
REQ-015 SHALL have port zz_out_flat, output, WIDTH_IN*64 bits, signed: buffered zigzag block, entry k at bits [k*WIDTH_IN +: WIDTH_IN].
REQ-016 SHALL have port quant_out_flat, output, WIDTH_IN*64 bits: selected table, row-major, same packing.
REQ-017 SHALL have port out_valid, output, 1 bit: zz_out_flat and quant_out_flat hold a complete block.
REQ-018 SHALL have port out_ready, input, 1 bit: downstream transform consumes the block.
REQ-019 SHALL have port blk_overrun, output, 1 bit: sticky flag, block ended at 64 coefficients without coef_last.

Function
REQ-020 SHALL implement states IDLE (count=0, awaiting first coefficient), FILL (1..63 coefficients held) and HOLD (block complete).
REQ-021 SHALL drive coef_ready=1 in IDLE and FILL and coef_ready=0 in HOLD.
REQ-022 SHALL, on acceptance in IDLE: write coef_data to entry 0, zero entries 1..63 in the same cycle, latch blk_qt_sel, set count=1 and go to FILL (or go to HOLD if coef_last=1).
REQ-023 SHALL, on acceptance in FILL, write coef_data to entry count and increment count.
REQ-024 SHALL enter HOLD the cycle after accepting coef_last, leaving the remaining entries zero.
REQ-025 SHALL enter HOLD after accepting the coefficient at count=63 even without coef_last, and SHALL set blk_overrun when coef_last=0 on that coefficient.
REQ-026 SHALL assert out_valid only in HOLD; latency from acceptance of the final coefficient to out_valid=1 is 1 cycle.
REQ-027 SHALL keep zz_out_flat and quant_out_flat constant while out_valid=1.
REQ-028 SHALL leave HOLD for IDLE on the cycle out_valid and out_ready are both high; coef_ready=1 from the next cycle; out_ready SHALL be ignored outside HOLD.
REQ-029 SHALL drive quant_out_flat combinationally from the latched table selector's storage.
REQ-030 SHALL apply a qt write the cycle after qt_wr_en in any state, except in HOLD when qt_wr_sel equals the latched selector: write dropped and qt_wr_err pulses for 1 cycle.
REQ-031 SHALL permit a qt write and a coefficient acceptance in the same cycle, without interaction.
REQ-032 SHALL ignore coef_data, coef_last and blk_qt_sel whenever coef_ready=0 or coef_valid=0.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, enter IDLE, clear count, buffer, latched selector, out_valid, qt_wr_err and blk_overrun, and abandon any partial or held block.
REQ-034 SHALL reset all quant table entries to 1.
REQ-035 SHALL drive coef_ready=1 in the first cycle after rst deasserts.

Verification
REQ-036 Full block: table 0 loaded with 2s, 64 coefficients 1..64 with coef_last on the 64th -> out_valid next cycle, zz_out_flat entry k = k+1, quant_out_flat all 2, blk_overrun=0.
REQ-037 EOB: 3 coefficients 10,-5,7 with coef_last on the third -> entries 0..2 = 10,-5,7, entries 3..63 = 0, out_valid 1 cycle after the third acceptance.
REQ-038 Backpressure: out_ready=0 for 5 cycles in HOLD -> coef_ready=0 and outputs stable throughout; after the handshake, coef_ready=1 the next cycle and the next block starts with a zeroed buffer.
REQ-039 Table protection: in HOLD with table 1 latched, write to table 1 -> qt_wr_err pulse, table unchanged; write to table 2 -> accepted, no pulse.
REQ-040 Overrun: 64 coefficients with no coef_last -> HOLD entered, blk_overrun=1 and remaining 1 until rst.
REQ-041 Reset mid-FILL after 20 coefficients -> IDLE, out_valid=0, coef_ready=1, quant tables all 1; the next block contains no data from the abandoned block.
